load_store_unit: RTL and testbench

- Parametrised multi-cycle load/store unit for the synapse32 memory stage.
- Replaces the single-cycle mem_read/mem_write path of control_unit.
- Adds a req/ready/rvalid bus handshake, byte/half/word (and double for XLEN=64) access with sign/zero extension, byte enables, misalignment and illegal-funct3 detection, and a bus timeout.
- Stalls the pipeline while a transaction is outstanding and delivers writeback data with a one-cycle done pulse.

---
 rtl/riscv_pkg.sv | 53 +++++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 208 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared opcode/funct3 constants, LSU state type and access helpers.
// Rev    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_st,
                                      input logic rv64);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_D:             ok = rv64;
            F3_BU, F3_HU:     ok = ~is_st;
            F3_WU:            ok = ~is_st & rv64;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Access size lives in funct3[1:0]; lo is the low three address bits.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [2:0] lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lo[0];
            2'b10:   mis = (lo[1:0] != 2'b00);
            2'b11:   mis = (lo != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Brief  : Store lane replication/byte enables and load lane extract/extend.
// Rev    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  store_data,
    output logic [NB-1:0]    store_be,
    output logic [XLEN-1:0]  store_wdata,
    input  logic [XLEN-1:0]  load_raw,
    output logic [XLEN-1:0]  load_data
);

    logic [XLEN-1:0] w_shift;

    always_comb begin
        w_shift     = load_raw >> {off, 3'b000};
        store_be    = '0;
        store_wdata = '0;
        load_data   = '0;

        case (funct3[1:0])
            2'b00: begin
                store_be    = NB'(1) << off;
                store_wdata = {NB{store_data[7:0]}};
            end
            2'b01: begin
                store_be    = NB'(3) << off;
                store_wdata = {(NB/2){store_data[15:0]}};
            end
            2'b10: begin
                store_be    = NB'(15) << off;
                store_wdata = {(NB/4){store_data[31:0]}};
            end
            default: begin
                store_be    = '1;
                store_wdata = store_data;
            end
        endcase

        case (funct3)
            F3_B:    load_data = XLEN'($signed(w_shift[7:0]));
            F3_H:    load_data = XLEN'($signed(w_shift[15:0]));
            F3_W:    load_data = XLEN'($signed(w_shift[31:0]));
            F3_D:    load_data = w_shift;
            F3_BU:   load_data = XLEN'(w_shift[7:0]);
            F3_HU:   load_data = XLEN'(w_shift[15:0]);
            F3_WU:   load_data = XLEN'(w_shift[31:0]);
            default: load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : Multi-cycle load/store unit with req/ready/rvalid handshake,
//          misalignment/illegal detection and bus timeout.
// Rev    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     rs1_input,
    input  logic [XLEN-1:0]     rs2_input,
    input  logic [XLEN-1:0]     imm,
    input  logic [4:0]          rd_addr,
    output logic                stall,
    output logic                op_done,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                exc_misaligned,
    output logic                exc_illegal,
    output logic                exc_access_fault,
    output logic [ADDR_W-1:0]   fault_addr,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int c_NB    = XLEN / 8;
    localparam int c_OFF_W = $clog2(c_NB);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic c_RV64 = (XLEN == 64);

    lsu_state_t          r_state;
    logic [ADDR_W-1:0]   r_ea;
    logic [c_OFF_W-1:0]  r_off;
    logic [2:0]          r_funct3;
    logic [4:0]          r_rd;
    logic                r_is_store;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_start;
    logic                w_is_store;
    logic [XLEN-1:0]     w_sum;
    logic [ADDR_W-1:0]   w_ea;
    logic [c_OFF_W-1:0]  w_off;
    logic                w_illegal;
    logic                w_misaligned;
    logic                w_timeout;
    logic [2:0]          w_align_f3;
    logic [c_OFF_W-1:0]  w_align_off;
    logic [c_NB-1:0]     w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_load_data;

    assign w_start      = (r_state == ST_IDLE) & valid_in & (is_load | is_store);
    assign w_is_store   = is_store & ~is_load;
    assign w_sum        = rs1_input + imm;
    assign w_ea         = w_sum[ADDR_W-1:0];
    assign w_off        = w_ea[c_OFF_W-1:0];
    assign w_illegal    = ~f3_legal(funct3, w_is_store, c_RV64);
    assign w_misaligned = f3_misaligned(funct3, w_ea[2:0]);
    assign w_timeout    = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign stall        = w_start | (r_state == ST_REQ) | (r_state == ST_WAIT);

    // The shared aligner serves the incoming op while idle, the latched op afterwards.
    assign w_align_f3  = (r_state == ST_IDLE) ? funct3 : r_funct3;
    assign w_align_off = (r_state == ST_IDLE) ? w_off  : r_off;

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3      (w_align_f3),
        .off         (w_align_off),
        .store_data  (rs2_input),
        .store_be    (w_be),
        .store_wdata (w_wdata),
        .load_raw    (mem_rdata),
        .load_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_ea             <= '0;
            r_off            <= '0;
            r_funct3         <= '0;
            r_rd             <= '0;
            r_is_store       <= 1'b0;
            r_cnt            <= '0;
            op_done          <= 1'b0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_data          <= '0;
            exc_misaligned   <= 1'b0;
            exc_illegal      <= 1'b0;
            exc_access_fault <= 1'b0;
            fault_addr       <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            mem_be           <= '0;
        end else begin
            // Completion outputs are single-cycle; they are re-raised only on entry to DONE.
            op_done          <= 1'b0;
            wb_valid         <= 1'b0;
            wb_rd            <= '0;
            wb_data          <= '0;
            exc_misaligned   <= 1'b0;
            exc_illegal      <= 1'b0;
            exc_access_fault <= 1'b0;
            fault_addr       <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_ea       <= w_ea;
                        r_off      <= w_off;
                        r_funct3   <= funct3;
                        r_rd       <= rd_addr;
                        r_is_store <= w_is_store;
                        r_cnt      <= '0;
                        if (w_illegal || w_misaligned) begin
                            r_state        <= ST_DONE;
                            op_done        <= 1'b1;
                            wb_rd          <= rd_addr;
                            exc_illegal    <= w_illegal;
                            exc_misaligned <= ~w_illegal;
                            fault_addr     <= w_ea;
                        end else begin
                            r_state   <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= w_is_store;
                            mem_addr  <= {w_ea[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};
                            mem_be    <= w_be;
                            mem_wdata <= w_is_store ? w_wdata : '0;
                        end
                    end
                end

                ST_REQ: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (mem_ready || w_timeout) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end
                    if (mem_ready) begin
                        if (r_is_store) begin
                            r_state <= ST_DONE;
                            op_done <= 1'b1;
                            wb_rd   <= r_rd;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (w_timeout) begin
                        r_state          <= ST_DONE;
                        op_done          <= 1'b1;
                        wb_rd            <= r_rd;
                        exc_access_fault <= 1'b1;
                        fault_addr       <= r_ea;
                    end
                end

                ST_WAIT: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (mem_rvalid) begin
                        r_state  <= ST_DONE;
                        op_done  <= 1'b1;
                        wb_rd    <= r_rd;
                        wb_valid <= (r_rd != 5'd0);
                        wb_data  <= (r_rd != 5'd0) ? w_load_data : '0;
                    end else if (w_timeout) begin
                        r_state          <= ST_DONE;
                        op_done          <= 1'b1;
                        wb_rd            <= r_rd;
                        exc_access_fault <= 1'b1;
                        fault_addr       <= r_ea;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed self-checking bench for load_store_unit (XLEN=32, timeout 8).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] rs1_input, rs2_input, imm;
    logic [4:0]  rd_addr;
    logic        stall, op_done, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misaligned, exc_illegal, exc_access_fault;
    logic [31:0] fault_addr;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    load_store_unit #(
        .XLEN           (32),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .is_load          (is_load),
        .is_store         (is_store),
        .funct3           (funct3),
        .rs1_input        (rs1_input),
        .rs2_input        (rs2_input),
        .imm              (imm),
        .rd_addr          (rd_addr),
        .stall            (stall),
        .op_done          (op_done),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .exc_misaligned   (exc_misaligned),
        .exc_illegal      (exc_illegal),
        .exc_access_fault (exc_access_fault),
        .fault_addr       (fault_addr),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_ready        (mem_ready),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single accept cycle; stall must be high combinationally.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] im, input logic [4:0] rd);
        valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        rs1_input = a; rs2_input = d; imm = im; rd_addr = rd;
        #1;
        chk("stall_accept", stall, 1);
        step();
        valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    // Zero-wait load: ready one cycle after accept, rvalid the next; ends in DONE.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] im, input logic [4:0] rd,
                           input logic [31:0] rdata);
        issue(1'b1, 1'b0, f3, a, 32'h0, im, rd);
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ready = 1'b0; mem_rdata = rdata;
        chk("wait_no_done", op_done, 0);
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        rs1_input = '0; rs2_input = '0; imm = '0; rd_addr = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_outs", {op_done, wb_valid, exc_misaligned, exc_illegal, exc_access_fault, stall}, 0);
        chk("rst_buses", {mem_addr, mem_wdata}, 0);
        chk("rst_wb", {wb_data, fault_addr}, 0);
        rst = 1'b0;
        step();

        // SW 0xDEADBEEF to 0x104
        issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h4, 5'd0);
        chk("sw_req", {mem_req, mem_we}, 2'b11);
        chk("sw_addr", mem_addr, 32'h104);
        chk("sw_be", mem_be, 4'hF);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("sw_no_done_c1", op_done, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sw_done", op_done, 1);
        chk("sw_wb_valid", wb_valid, 0);
        chk("sw_req_drop", mem_req, 0);
        chk("sw_stall_done", stall, 0);
        step();
        chk("sw_done_1cyc", op_done, 0);

        // LB / LBU / LH at byte 3 / half 2 of 0x80FF7F00
        do_load(3'b000, 32'h200, 32'h3, 5'd5, 32'h80FF_7F00);
        chk("lb_done", {op_done, wb_valid}, 2'b11);
        chk("lb_rd", wb_rd, 5'd5);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        step();
        do_load(3'b100, 32'h200, 32'h3, 5'd6, 32'h80FF_7F00);
        chk("lbu_rd", wb_rd, 5'd6);
        chk("lbu_data", wb_data, 32'h0000_0080);
        step();
        do_load(3'b001, 32'h200, 32'h2, 5'd7, 32'h80FF_7F00);
        chk("lh_data", wb_data, 32'hFFFF_80FF);
        step();

        // SH at 0x12, SB at 0x701
        issue(1'b0, 1'b1, 3'b001, 32'h10, 32'h1234_ABCD, 32'h2, 5'd0);
        chk("sh_addr", mem_addr, 32'h10);
        chk("sh_be", mem_be, 4'hC);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sh_done", op_done, 1);
        step();
        issue(1'b0, 1'b1, 3'b000, 32'h700, 32'h5555_55AB, 32'h1, 5'd0);
        chk("sb_be", mem_be, 4'h2);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();

        // LH misaligned at 0x11
        issue(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'h1, 5'd3);
        chk("mis_done", {op_done, exc_misaligned, exc_illegal, exc_access_fault}, 4'b1100);
        chk("mis_addr", fault_addr, 32'h11);
        chk("mis_no_req", mem_req, 0);
        chk("mis_wb_valid", wb_valid, 0);
        chk("mis_stall", stall, 0);
        step();

        // LW with the bus never ready: fault after 8 cycles in REQ
        issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd7);
        for (int i = 1; i <= 8; i++) begin
            chk("to_pending", {stall, mem_req, op_done}, 3'b110);
            step();
        end
        chk("to_fault", {op_done, exc_access_fault, exc_misaligned, exc_illegal}, 4'b1100);
        chk("to_addr", fault_addr, 32'h300);
        chk("to_req_drop", {mem_req, wb_valid}, 0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        chk("to_late_rvalid", {op_done, wb_valid, stall}, 0);

        // Reset while in WAIT
        issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 5'd8);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_outs", {op_done, wb_valid, mem_req, stall, exc_access_fault}, 0);
        chk("rstw_buses", {mem_addr, wb_data}, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_rvalid = 1'b0;
        chk("rstw_ignored", {op_done, wb_valid}, 0);
        do_load(3'b010, 32'h400, 32'h4, 5'd9, 32'hCAFE_F00D);
        chk("rstw_next", {op_done, wb_valid, wb_rd}, {2'b11, 5'd9});
        chk("rstw_next_data", wb_data, 32'hCAFE_F00D);
        step();

        // Illegal funct3, including one that is also misaligned
        issue(1'b1, 1'b0, 3'b111, 32'h500, 32'h0, 32'h0, 5'd4);
        chk("ill_done", {op_done, exc_illegal, exc_misaligned, mem_req}, 4'b1100);
        chk("ill_addr", fault_addr, 32'h500);
        step();
        issue(1'b1, 1'b0, 3'b111, 32'h500, 32'h0, 32'h1, 5'd4);
        chk("ill_prio", {exc_illegal, exc_misaligned}, 2'b10);
        step();
        issue(1'b0, 1'b1, 3'b100, 32'h500, 32'h0, 32'h0, 5'd0);
        chk("ill_sbu", {op_done, exc_illegal}, 2'b11);
        step();

        // LW to x0
        do_load(3'b010, 32'h600, 32'h0, 5'd0, 32'h1111_1111);
        chk("x0_done", {op_done, wb_valid}, 2'b10);
        chk("x0_data", wb_data, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
